// File: rtl/fir_sched_pkg.sv
// Shared constants and elaboration-time helpers for the FIR round-robin scheduler.
package fir_sched_pkg;

  localparam int NCH_DEF    = 32'd3;
  localparam int DATA_W_DEF = 32'd32;
  localparam int CRED_DEF   = 32'd2;

  function automatic int clog2(input int value);
    int r;
    r = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) begin
        r = i + 32'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_rr_scheduler_rr_arbiter.sv
// Combinational NCH-way round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter
  import fir_sched_pkg::*;
#(
  parameter  int NCH  = NCH_DEF,
  localparam int ID_W = clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [ID_W-1:0] ptr,
  output logic [NCH-1:0]  grant,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  // Scan channels in rotated order and keep only the first hit.
  always_comb begin
    logic [ID_W-1:0] cand_s;
    logic            hit_s;
    grant  = '0;
    idx    = '0;
    any    = 1'b0;
    cand_s = '0;
    hit_s  = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      cand_s        = ID_W'((int'(ptr) + k) % NCH);
      hit_s         = !any && req[cand_s];
      grant[cand_s] = grant[cand_s] | hit_s;
      idx           = hit_s ? cand_s : idx;
      any           = any | hit_s;
    end
  end

endmodule

// File: rtl/fir_rr_scheduler.sv
// Time-shares one FIR section between NCH valid/ready streams with per-channel
// credits bounding in-flight samples and tagged results routed to output registers.
module fir_rr_scheduler
  import fir_sched_pkg::*;
#(
  parameter  int NCH    = NCH_DEF,
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int CRED   = CRED_DEF,
  localparam int ID_W   = clog2(NCH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NCH-1:0]        in_valid,
  output logic [NCH-1:0]        in_ready,
  input  logic [NCH*DATA_W-1:0] in_bits,
  output logic                  dp_req_valid,
  input  logic                  dp_req_ready,
  output logic [DATA_W-1:0]     dp_req_bits,
  output logic [ID_W-1:0]       dp_req_id,
  input  logic                  dp_rsp_valid,
  output logic                  dp_rsp_ready,
  input  logic [DATA_W-1:0]     dp_rsp_bits,
  input  logic [ID_W-1:0]       dp_rsp_id,
  output logic [NCH-1:0]        out_valid,
  input  logic [NCH-1:0]        out_ready,
  output logic [NCH*DATA_W-1:0] out_bits,
  output logic                  busy
);

  localparam int CW = clog2(CRED + 1);

  logic [NCH-1:0]    eligible_s;
  logic [NCH-1:0]    grant_s;
  logic [NCH-1:0]    in_hs_s;
  logic [NCH-1:0]    out_hs_s;
  logic [ID_W-1:0]   idx_s;
  logic              any_s;
  logic              load_s;
  logic              rsp_hs_s;
  logic              busy_s;

  logic [ID_W-1:0]   ptr_r;
  logic [CW-1:0]     credit_r [NCH];
  logic              req_valid_r;
  logic [DATA_W-1:0] req_bits_r;
  logic [ID_W-1:0]   req_id_r;
  logic [NCH-1:0]    out_valid_r;
  logic [DATA_W-1:0] out_bits_r [NCH];

  // A channel may compete only while it has a free credit.
  always_comb begin
    eligible_s = '0;
    for (int i = 0; i < NCH; i++) begin
      eligible_s[i] = in_valid[i] & (credit_r[i] < CW'(CRED));
    end
  end

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req   (eligible_s),
    .ptr   (ptr_r),
    .grant (grant_s),
    .idx   (idx_s),
    .any   (any_s)
  );

  // reset gating keeps in_ready low while the design is held in reset.
  assign load_s       = reset & enable & any_s & (!req_valid_r | dp_req_ready);
  assign in_ready     = load_s ? grant_s : '0;
  assign in_hs_s      = in_valid & in_ready;
  assign out_hs_s     = out_valid_r & out_ready;
  assign dp_rsp_ready = !out_valid_r[dp_rsp_id] | out_ready[dp_rsp_id];
  assign rsp_hs_s     = dp_rsp_valid & dp_rsp_ready;

  assign dp_req_valid = req_valid_r;
  assign dp_req_bits  = req_bits_r;
  assign dp_req_id    = req_id_r;
  assign out_valid    = out_valid_r;
  assign busy         = busy_s;

  // Activity flag from registered state only.
  always_comb begin
    busy_s = req_valid_r;
    for (int i = 0; i < NCH; i++) begin
      busy_s = busy_s | (credit_r[i] != '0);
    end
  end

  // Flatten per-channel result registers onto the output bus.
  always_comb begin
    out_bits = '0;
    for (int i = 0; i < NCH; i++) begin
      out_bits[i*DATA_W +: DATA_W] = out_bits_r[i];
    end
  end

  // Request register and priority pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_valid_r <= 1'b0;
      req_bits_r  <= '0;
      req_id_r    <= '0;
      ptr_r       <= '0;
    end else if (load_s) begin
      req_valid_r <= 1'b1;
      req_bits_r  <= in_bits[int'(idx_s)*DATA_W +: DATA_W];
      req_id_r    <= idx_s;
      ptr_r       <= (idx_s == ID_W'(NCH - 1)) ? '0 : idx_s + 1'b1;
    end else if (dp_req_ready) begin
      req_valid_r <= 1'b0;
    end else begin
      req_valid_r <= req_valid_r;
    end
  end

  // Credits count samples between input acceptance and output consumption.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        credit_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (in_hs_s[i] && !out_hs_s[i] && (credit_r[i] != CW'(CRED))) begin
          credit_r[i] <= credit_r[i] + 1'b1;
        end else if (out_hs_s[i] && !in_hs_s[i] && (credit_r[i] != '0)) begin
          credit_r[i] <= credit_r[i] - 1'b1;
        end else begin
          credit_r[i] <= credit_r[i];
        end
      end
    end
  end

  // One-entry output registers; a reload wins over a same-cycle drain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_r <= '0;
      for (int i = 0; i < NCH; i++) begin
        out_bits_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (rsp_hs_s && (dp_rsp_id == ID_W'(i))) begin
          out_valid_r[i] <= 1'b1;
          out_bits_r[i]  <= dp_rsp_bits;
        end else if (out_hs_s[i]) begin
          out_valid_r[i] <= 1'b0;
        end else begin
          out_valid_r[i] <= out_valid_r[i];
        end
      end
    end
  end

endmodule

// File: doc/fir_rr_scheduler.md
# fir_rr_scheduler

Round-robin scheduler that time-shares one FIR filter-section datapath between NCH independent valid/ready sample streams. Requests carry a channel tag into the shared section. Tagged results are routed back to per-channel output registers. Per-channel credit counters bound in-flight samples, so one stalled consumer cannot starve the others. It sits between the channel front-ends and a single filter-section pipeline whose latency and stalls are opaque to the scheduler.

## Interface
Parameters:
- NCH, 3, number of requester channels (2..8)
- DATA_W, 32, sample width
- CRED, 2, max in-flight samples per channel (1..7)
- ID_W, clog2(NCH), channel tag width (derived; not overridable)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low (asserted at 0); clears all state immediately
- enable  in  1  1 = new grants allowed; 0 = in-flight work drains, no new grants
- in_valid  in  NCH  per-channel sample valid
- in_ready  out  NCH  per-channel accept
- in_bits  in  NCH*DATA_W  per-channel samples, channel i at [i*DATA_W +: DATA_W]
- dp_req_valid  out  1  request to shared section
- dp_req_ready  in  1  shared section accepts
- dp_req_bits  out  DATA_W  sample
- dp_req_id  out  ID_W  channel tag
- dp_rsp_valid  in  1  result from shared section
- dp_rsp_ready  out  1  scheduler accepts result
- dp_rsp_bits  in  DATA_W  result
- dp_rsp_id  in  ID_W  result tag; values ≥ NCH never occur
- out_valid  out  NCH  per-channel result valid
- out_ready  in  NCH  per-channel consumer ready
- out_bits  out  NCH*DATA_W  per-channel results
- busy  out  1  any credit nonzero, or dp_req_valid

## Operation
- Request register (dp_req_valid/bits/id) loads when `load = enable & any_eligible & (!dp_req_valid | dp_req_ready)`.
- Eligible channel: `in_valid[i] & credit[i] < CRED`.
- Grant: first eligible channel at or after priority pointer `ptr`, wrapping modulo NCH. `in_ready[i] = load & grant[i]`. At most one in_ready bit set per cycle.
- On load: `ptr <= grant+1` (wraps NCH-1 → 0). The pointer is unchanged when nothing loads.
- When dp_req_ready is high and no load occurs, dp_req_valid drops to 0. The request register holds its contents while `dp_req_valid & !dp_req_ready`.
- credit[i] increments on in handshake of channel i and decrements on out handshake of channel i. When both happen in the same cycle the credit is unchanged. Width is clog2(CRED+1). It never exceeds CRED and never underflows.
- Each channel has a one-entry output register. `dp_rsp_ready = !out_valid[dp_rsp_id] | out_ready[dp_rsp_id]`. On rsp handshake, out_bits[id] is loaded and out_valid[id] is set. out_valid[i] clears on out handshake without a simultaneous reload.
- Results are delivered in dp_rsp order. No reordering is done.
- enable low: in_ready all 0. Pending request, responses and outputs continue normally.

## Timing
- Reset values: in_ready=0, dp_req_valid=0, dp_req_bits=0, dp_req_id=0, dp_rsp_ready=1, out_valid=0, out_bits=0, busy=0, ptr=0, credits=0.
- in handshake at cycle t → dp_req_valid=1 at t+1. Throughput is 1 sample/cycle aggregate.
- rsp handshake at cycle t → out_valid[id]=1 at t+1. Same-cycle out handshake plus reload keeps out_valid=1 with the new data.
- in_ready is combinational from in_valid, credits, enable, dp_req_ready. dp_rsp_ready is combinational from dp_rsp_id and out_ready. No other comb paths.
- Reset asserted mid-operation: all state is cleared asynchronously, and in-flight samples are discarded. Deassertion is synchronized externally.

## Structure
- A shared package `fir_sched_pkg` holds the default NCH/DATA_W/CRED constants and a `clog2` function.
- Sub-module `rr_arbiter`: combinational NCH-way round-robin picker, ptr in, one-hot grant + index out. The parent module owns ptr, credits, the request register and the output registers.

## Test plan
- Single channel 0, CRED=2, dp section 1-cycle loopback (result = sample), send 0x10, 0x20 → dp_req_id 0 twice; out_bits[0] = 0x10 then 0x20; credit returns to 0; busy=0.
- All three channels continuously valid, all ready high → dp_req_id sequence 0,1,2,0,1,2 with no idle cycles.
- Channel 1 out_ready held 0, CRED=2 → after 2 grants to ch1, in_ready[1]=0 while ch0/ch2 keep alternating; release out_ready[1] → ch1 regranted within 3 cycles.
- dp_req_ready held 0 for 5 cycles with request 0xABCD id 2 pending → dp_req_bits/id stable, in_ready all 0; on release, the next grant goes to ch0 (ptr=0).
- rsp for ch0 arrives while out_valid[0]=1 and out_ready[0]=0 → dp_rsp_ready=0; assert out_ready[0] → handshake, old value consumed, new value visible next cycle.
- Reset pulled low mid-stream with credits {1,2,0} → the same edge clears in_ready, out_valid, dp_req_valid and credits to 0; after release the first grant goes to ch0.
